// File: rtl/m_dmem_responder.sv
// m_dmem_responder: memory end of a valid/ready load/store interface.
// One request at a time is accepted, then WAIT_CYCLES wait states are inserted.
// The access is performed on a single edge: a byte-masked store commit, or a
// load read. Read data and an error flag are then returned on a separate
// valid/ready response channel.
//
// Ports
//   w_clk, w_rst_n      clock, asynchronous active-low reset
//   w_req_valid/ready   request handshake (ready only while idle)
//   w_req_addr          byte address; word index is addr[DEPTH_LOG2+1:2]
//   w_req_we            1 = store, 0 = load
//   w_req_wstrb         byte-lane enables for stores
//   w_req_wdata         store data
//   w_rsp_valid/ready   response handshake
//   w_rsp_rdata         load data (0 for stores and errors)
//   w_rsp_err           misaligned or out-of-range address
module m_dmem_responder #(
    parameter  int unsigned DEPTH_LOG2  = 6,
    parameter  int unsigned WAIT_CYCLES = 2,
    localparam int unsigned AW          = 32,
    localparam int unsigned DW          = 32,
    localparam int unsigned SW          = DW / 8
) (
    input  logic          w_clk,
    input  logic          w_rst_n,
    input  logic          w_req_valid,
    output logic          w_req_ready,
    input  logic [AW-1:0] w_req_addr,
    input  logic          w_req_we,
    input  logic [SW-1:0] w_req_wstrb,
    input  logic [DW-1:0] w_req_wdata,
    output logic          w_rsp_valid,
    input  logic          w_rsp_ready,
    output logic [DW-1:0] w_rsp_rdata,
    output logic          w_rsp_err
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W     = 4;
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        ZERO_WAIT ? CNT_W'(0) : CNT_W'(WAIT_CYCLES - 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [SW-1:0] wstrb;
        logic [DW-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    req_t             req_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [DW-1:0]    rsp_rdata_q;
    logic             rsp_err_q;

    // Storage has no reset; contents survive a reset of the control path.
    logic [DW-1:0]    mem_q [DEPTH];

    req_t                  req_in_c;
    req_t                  acc_c;
    logic                  acc_fire_c;
    logic                  acc_err_c;
    logic [DEPTH_LOG2-1:0] acc_idx_c;
    logic [DW-1:0]         acc_rdata_c;
    logic                  mem_we_c;

    // Access decode. With no wait states the access happens on the accepting
    // edge, so it must use the live request rather than the latched copy.
    always_comb begin
        req_in_c.addr  = w_req_addr;
        req_in_c.we    = w_req_we;
        req_in_c.wstrb = w_req_wstrb;
        req_in_c.wdata = w_req_wdata;

        acc_c      = ZERO_WAIT ? req_in_c : req_q;
        acc_fire_c = ZERO_WAIT ? ((state_q == ST_IDLE) && w_req_valid)
                               : ((state_q == ST_WAIT) && (cnt_q == '0));

        acc_err_c  = (acc_c.addr[1:0] != 2'b00)
                  || (acc_c.addr[AW-1:DEPTH_LOG2+2] != '0);
        acc_idx_c  = acc_c.addr[DEPTH_LOG2+1:2];

        acc_rdata_c = '0;
        if (!acc_c.we && !acc_err_c) begin
            acc_rdata_c = mem_q[acc_idx_c];
        end

        mem_we_c = acc_fire_c && acc_c.we && !acc_err_c;
    end

    // Byte-lane store commit on the edge that enters RESP.
    always_ff @(posedge w_clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < SW; i++) begin
                if (acc_c.wstrb[i]) begin
                    mem_q[acc_idx_c][8*i +: 8] <= acc_c.wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_req_valid) begin
                        req_q       <= req_in_c;
                        req_ready_q <= 1'b0;
                        if (ZERO_WAIT) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= acc_rdata_c;
                            rsp_err_q   <= acc_err_c;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end

                ST_WAIT: begin
                    // Counter stops at zero; the zero cycle is the access edge.
                    if (cnt_q == '0) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= acc_rdata_c;
                        rsp_err_q   <= acc_err_c;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_RESP: begin
                    if (w_rsp_ready) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign w_req_ready = req_ready_q;
    assign w_rsp_valid = rsp_valid_q;
    assign w_rsp_rdata = rsp_rdata_q;
    assign w_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_m_dmem_responder.sv
// Directed bench for m_dmem_responder: instance A uses 2 wait states,
// instance B uses 0 wait states. Outputs are sampled on the falling edge.
module tb_m_dmem_responder;

    logic w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    logic w_rst_n;

    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic [3:0]  a_req_wstrb;

    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [3:0]  b_req_wstrb;

    int total = 0;
    int bad   = 0;

    m_dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) u_dut_a (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .w_req_valid (a_req_valid),
        .w_req_ready (a_req_ready),
        .w_req_addr  (a_req_addr),
        .w_req_we    (a_req_we),
        .w_req_wstrb (a_req_wstrb),
        .w_req_wdata (a_req_wdata),
        .w_rsp_valid (a_rsp_valid),
        .w_rsp_ready (a_rsp_ready),
        .w_rsp_rdata (a_rsp_rdata),
        .w_rsp_err   (a_rsp_err)
    );

    m_dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) u_dut_b (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .w_req_valid (b_req_valid),
        .w_req_ready (b_req_ready),
        .w_req_addr  (b_req_addr),
        .w_req_we    (b_req_we),
        .w_req_wstrb (b_req_wstrb),
        .w_req_wdata (b_req_wdata),
        .w_rsp_valid (b_rsp_valid),
        .w_rsp_ready (b_rsp_ready),
        .w_rsp_rdata (b_rsp_rdata),
        .w_rsp_err   (b_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input bit sel, input logic we, input logic [31:0] addr,
                             input logic [3:0] strb, input logic [31:0] wd);
        if (sel) begin
            b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr;
            b_req_wstrb = strb; b_req_wdata = wd;
        end else begin
            a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr;
            a_req_wstrb = strb; a_req_wdata = wd;
        end
    endtask

    // Full transaction with rsp_ready already high; starts and ends at a falling edge.
    task automatic xact(input bit sel, input logic we, input logic [31:0] addr,
                        input logic [3:0] strb, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        drive_req(sel, we, addr, strb, wd);
        n = 0;
        while (!(sel ? b_req_ready : a_req_ready) && n < 50) begin
            @(negedge w_clk); n++;
        end
        @(posedge w_clk);
        @(negedge w_clk);
        if (sel) b_req_valid = 1'b0; else a_req_valid = 1'b0;
        lat = 1;
        while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 50) begin
            @(negedge w_clk); lat++;
        end
        rd = sel ? b_rsp_rdata : a_rsp_rdata;
        er = sel ? b_rsp_err : a_rsp_err;
        @(posedge w_clk);
        @(negedge w_clk);
    endtask

    task automatic st(input bit sel, input logic [31:0] addr, input logic [3:0] strb,
                      input logic [31:0] wd, input logic exp_err, input string tag);
        logic [31:0] rd; logic er; int lat;
        xact(sel, 1'b1, addr, strb, wd, rd, er, lat);
        chk({tag, ".rdata"}, rd, 32'h0);
        chk({tag, ".err"}, 32'(er), 32'(exp_err));
        chk({tag, ".lat"}, 32'(lat), sel ? 32'd1 : 32'd3);
    endtask

    task automatic ld(input bit sel, input logic [31:0] addr, input logic [31:0] exp_d,
                      input logic exp_err, input string tag);
        logic [31:0] rd; logic er; int lat;
        xact(sel, 1'b0, addr, 4'h0, 32'h0, rd, er, lat);
        chk({tag, ".rdata"}, rd, exp_d);
        chk({tag, ".err"}, 32'(er), 32'(exp_err));
        chk({tag, ".lat"}, 32'(lat), sel ? 32'd1 : 32'd3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        w_rst_n     = 1'b0;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wstrb = '0; a_req_wdata = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wstrb = '0; b_req_wdata = '0;
        a_rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;

        // reset state
        repeat (2) @(negedge w_clk);
        chk("rst.a_req_ready", 32'(a_req_ready), 32'd1);
        chk("rst.a_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst.a_rsp_rdata", a_rsp_rdata, 32'd0);
        chk("rst.a_rsp_err",   32'(a_rsp_err), 32'd0);
        chk("rst.b_req_ready", 32'(b_req_ready), 32'd1);
        chk("rst.b_rsp_valid", 32'(b_rsp_valid), 32'd0);
        w_rst_n = 1'b1;
        @(negedge w_clk);

        // known contents for later checks
        st(0, 32'h00, 4'hF, 32'hCAFE_F00D, 1'b0, "init00");
        st(0, 32'h04, 4'hF, 32'h0000_0000, 1'b0, "init04");
        st(0, 32'h20, 4'hF, 32'h1122_3344, 1'b0, "init20");

        // store then load
        st(0, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, "st10");
        ld(0, 32'h10, 32'hDEAD_BEEF, 1'b0, "ld10");

        // byte strobes: lanes 0 and 2 replaced
        st(0, 32'h20, 4'b0101, 32'hAABB_CCDD, 1'b0, "strb20");
        ld(0, 32'h20, 32'h11BB_33DD, 1'b0, "ld20");

        // errors and no side effects
        ld(0, 32'h12, 32'h0, 1'b1, "mis12");
        st(0, 32'h100, 4'hF, 32'h1234_5678, 1'b1, "oor100");
        ld(0, 32'h8000_0000, 32'h0, 1'b1, "oorhi");
        ld(0, 32'h10, 32'hDEAD_BEEF, 1'b0, "keep10");
        ld(0, 32'h00, 32'hCAFE_F00D, 1'b0, "keep00");

        // empty strobe store and top word
        st(0, 32'h10, 4'h0, 32'hFFFF_FFFF, 1'b0, "nostrb");
        ld(0, 32'h10, 32'hDEAD_BEEF, 1'b0, "nostrb_ld");
        st(0, 32'hFC, 4'hF, 32'h0BAD_C0DE, 1'b0, "stFC");
        ld(0, 32'hFC, 32'h0BAD_C0DE, 1'b0, "ldFC");

        // backpressure with a second request waiting
        a_rsp_ready = 1'b0;
        drive_req(0, 1'b0, 32'h10, 4'h0, 32'h0);
        @(posedge w_clk);
        @(negedge w_clk);
        drive_req(0, 1'b0, 32'h20, 4'h0, 32'h0);
        n = 0;
        while (!a_rsp_valid && n < 50) begin @(negedge w_clk); n++; end
        chk("bp.first_valid", 32'(a_rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge w_clk);
            chk("bp.valid",     32'(a_rsp_valid), 32'd1);
            chk("bp.rdata",     a_rsp_rdata, 32'hDEAD_BEEF);
            chk("bp.err",       32'(a_rsp_err), 32'd0);
            chk("bp.req_ready", 32'(a_req_ready), 32'd0);
        end
        a_rsp_ready = 1'b1;
        @(posedge w_clk);
        @(negedge w_clk);
        chk("bp.idle_ready", 32'(a_req_ready), 32'd1);
        chk("bp.idle_valid", 32'(a_rsp_valid), 32'd0);
        @(posedge w_clk);
        @(negedge w_clk);
        a_req_valid = 1'b0;
        chk("bp.accepted", 32'(a_req_ready), 32'd0);
        n = 1;
        while (!a_rsp_valid && n < 50) begin @(negedge w_clk); n++; end
        chk("bp.second_lat",   32'(n), 32'd3);
        chk("bp.second_rdata", a_rsp_rdata, 32'h11BB_33DD);
        @(posedge w_clk);
        @(negedge w_clk);

        // reset during WAIT drops the store
        drive_req(0, 1'b1, 32'h04, 4'hF, 32'h5);
        @(posedge w_clk);
        @(negedge w_clk);
        a_req_valid = 1'b0;
        chk("rstw.pre_ready", 32'(a_req_ready), 32'd0);
        #1 w_rst_n = 1'b0;
        #1;
        chk("rstw.req_ready", 32'(a_req_ready), 32'd1);
        chk("rstw.rsp_valid", 32'(a_rsp_valid), 32'd0);
        #1 w_rst_n = 1'b1;
        @(negedge w_clk);
        ld(0, 32'h04, 32'h0, 1'b0, "rstw.ld04");

        // reset during RESP keeps the committed store
        a_rsp_ready = 1'b0;
        drive_req(0, 1'b1, 32'h0C, 4'hF, 32'h99);
        @(posedge w_clk);
        @(negedge w_clk);
        a_req_valid = 1'b0;
        n = 0;
        while (!a_rsp_valid && n < 50) begin @(negedge w_clk); n++; end
        chk("rstr.pre_valid", 32'(a_rsp_valid), 32'd1);
        #1 w_rst_n = 1'b0;
        #1;
        chk("rstr.rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rstr.req_ready", 32'(a_req_ready), 32'd1);
        #1 w_rst_n = 1'b1;
        a_rsp_ready = 1'b1;
        @(negedge w_clk);
        ld(0, 32'h0C, 32'h99, 1'b0, "rstr.ld0C");

        // zero wait states
        st(1, 32'h30, 4'hF, 32'hA5A5_0F0F, 1'b0, "b.st30");
        ld(1, 32'h30, 32'hA5A5_0F0F, 1'b0, "b.ld30");
        ld(1, 32'h31, 32'h0, 1'b1, "b.mis31");
        st(1, 32'h30, 4'b1000, 32'h7700_0000, 1'b0, "b.strb30");

        // back-to-back loads with rsp_ready tied high
        drive_req(1, 1'b0, 32'h30, 4'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge w_clk);
            chk("b2b.rsp_valid", 32'(b_rsp_valid), 32'((i % 2) == 0));
            chk("b2b.req_ready", 32'(b_req_ready), 32'((i % 2) == 1));
            if ((i % 2) == 0) chk("b2b.rdata", b_rsp_rdata, 32'h77A5_0F0F);
        end
        b_req_valid = 1'b0;
        @(negedge w_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
